// File: rtl/data_sync.sv
// data_sync: enable-qualified data-bus synchronizer for clock-domain crossings.
// Only the level enable is passed through a NUM_STAGES flop chain; the bus is
// captured into the destination domain on the rising edge of the synchronized
// enable, relying on the source keeping the bus stable around the transfer.
// Build option: define DATA_SYNC_PULSE_REG_EN to register enable_pulse so it
// coincides with the sync_bus update; otherwise enable_pulse is the
// combinational edge detect, one cycle ahead of the sync_bus update.
module data_sync #(
  parameter int NUM_STAGES = 2,
  parameter int BUS_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] Unsync_bus,
  input  logic                 bus_enable,
  output logic [BUS_WIDTH-1:0] sync_bus,
  output logic                 enable_pulse
);

  // A single-flop chain cannot resolve metastability, so reject it at elaboration.
  if (NUM_STAGES < 2) begin : g_bad_stages
    $error("data_sync: NUM_STAGES must be at least 2");
  end

  // Bit 0 is the stage that samples bus_enable; the top bit is sync_en.
  logic [NUM_STAGES-1:0] sync_chain_q;
  logic [NUM_STAGES-1:0] sync_chain_d;
  logic                  sync_en;
  logic                  sync_en_dly_q;  // sync_en delayed by one cycle
  logic                  pulse_gen;
  logic [BUS_WIDTH-1:0]  sync_bus_q;
  logic [BUS_WIDTH-1:0]  sync_bus_d;

  // Next-state: shift the enable down the chain and select the bus on a new edge.
  always_comb begin
    sync_chain_d = {sync_chain_q[NUM_STAGES-2:0], bus_enable};
    sync_bus_d   = sync_bus_q;
    if (pulse_gen) begin
      sync_bus_d = Unsync_bus;
    end
  end

  assign sync_en   = sync_chain_q[NUM_STAGES-1];
  assign pulse_gen = sync_en & ~sync_en_dly_q;

  // Enable synchronizer, edge-detect history and captured bus; reset aborts any transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_chain_q  <= '0;
      sync_en_dly_q <= 1'b0;
      sync_bus_q    <= '0;
    end else begin
      sync_chain_q  <= sync_chain_d;
      sync_en_dly_q <= sync_en;
      sync_bus_q    <= sync_bus_d;
    end
  end

  assign sync_bus = sync_bus_q;

`ifdef DATA_SYNC_PULSE_REG_EN
  logic enable_pulse_q;

  // Strobe registered alongside the bus capture so both change on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enable_pulse_q <= 1'b0;
    end else begin
      enable_pulse_q <= pulse_gen;
    end
  end

  assign enable_pulse = enable_pulse_q;
`else
  // Strobe straight from the edge detector; it is driven only by flops, so it is
  // glitch-free and leads the sync_bus update by one cycle.
  assign enable_pulse = pulse_gen;
`endif

endmodule

// File: tb/tb_data_sync.sv
// tb_data_sync: directed scoreboard bench for data_sync, covering the default
// configuration (2 stages, 8 bits) and a 3-stage, 16-bit instance side by side.
module tb_data_sync;

  logic        clk;
  logic        rst;
  logic [7:0]  ub2;
  logic        en2;
  logic [7:0]  sb2;
  logic        p2;
  logic [15:0] ub3;
  logic        en3;
  logic [15:0] sb3;
  logic        p3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  data_sync #(.NUM_STAGES(2), .BUS_WIDTH(8)) dut2 (
    .clk          (clk),
    .rst          (rst),
    .Unsync_bus   (ub2),
    .bus_enable   (en2),
    .sync_bus     (sb2),
    .enable_pulse (p2)
  );

  data_sync #(.NUM_STAGES(3), .BUS_WIDTH(16)) dut3 (
    .clk          (clk),
    .rst          (rst),
    .Unsync_bus   (ub3),
    .bus_enable   (en3),
    .sync_bus     (sb3),
    .enable_pulse (p3)
  );

  // Number of edges by which the strobe leads the sync_bus update.
`ifdef DATA_SYNC_PULSE_REG_EN
  localparam int PO = 0;
`else
  localparam int PO = 1;
`endif

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];
  int          sel      = 2;
  int          since    = 0;
  int          pulses   = 0;
  bit          pend     = 1'b0;
  int          pend_wait = 0;
  logic [15:0] pend_val = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample #1 after the rising edge, score pulses and captured data.
  task automatic tick();
    logic        p;
    logic [15:0] b;
    @(posedge clk);
    #1;
    since++;
    p = (sel == 3) ? p3 : p2;
    b = (sel == 3) ? sb3 : {8'h00, sb2};
    if (p === 1'b1) begin
      pulses++;
      chk("pulse_latency", since, ((sel == 3) ? 3 : 2) + 1 - PO);
      chk("scoreboard_pending", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        pend_val  = exp_q.pop_front();
        pend      = 1'b1;
        pend_wait = PO;
      end
    end
    if (pend) begin
      if (pend_wait == 0) begin
        chk("sync_bus_capture", b, pend_val);
        pend = 1'b0;
      end else begin
        pend_wait--;
      end
    end
  endtask

  // Full transfer: raise enable with the bus for 'hold' cycles, then 'low' cycles idle.
  task automatic transfer(input int s, input logic [15:0] v, input int hold, input int low);
    logic [15:0] e;
    e      = (s == 3) ? v : {8'h00, v[7:0]};
    sel    = s;
    pulses = 0;
    if (s == 3) begin
      ub3 = v;
      en3 = 1'b1;
    end else begin
      ub2 = v[7:0];
      en2 = 1'b1;
    end
    exp_q.push_back(e);
    since = 0;
    repeat (hold) tick();
    en2 = 1'b0;
    en3 = 1'b0;
    repeat (low) tick();
    chk("pulse_count", pulses, 1);
    chk("bus_held", (s == 3) ? sb3 : {8'h00, sb2}, e);
    chk("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    ub2 = '0;
    en2 = 1'b0;
    ub3 = '0;
    en3 = 1'b0;
    tick();

    // Reset with random inputs: outputs clear without a clock edge.
    ub2 = 8'($urandom);
    en2 = 1'($urandom_range(0, 1));
    ub3 = 16'($urandom);
    rst = 1'b0;
    #1;
    chk("reset_async_bus", sb2, 8'h00);
    chk("reset_async_pulse", p2, 1'b0);
    tick();
    en2 = 1'b0;
    rst = 1'b1;
    pulses = 0;
    repeat (4) tick();
    chk("post_reset_bus", sb2, 8'h00);
    chk("post_reset_pulses", pulses, 0);
    chk("post_reset_bus_w16", sb3, 16'h0000);

    // Basic transfer with enable held for 5 cycles.
    transfer(2, 16'h00AA, 5, 4);

    // Hold: bus changes while enable stays low.
    ub2 = 8'h55;
    pulses = 0;
    repeat (6) tick();
    chk("hold_bus", sb2, 8'hAA);
    chk("hold_pulses", pulses, 0);

    // Back-to-back transfers separated by 4 low cycles.
    transfer(2, 16'h003C, 4, 4);
    transfer(2, 16'h00C3, 4, 4);

    // Reset one cycle into a transfer; enable stays high across the release.
    ub2 = 8'hF0;
    en2 = 1'b1;
    exp_q.push_back(16'h00F0);
    pulses = 0;
    since = 0;
    tick();
    rst = 1'b0;
    #1;
    chk("midreset_bus", sb2, 8'h00);
    chk("midreset_pulse", p2, 1'b0);
    tick();
    chk("midreset_no_pulse", pulses, 0);
    rst = 1'b1;
    since = 0;
    repeat (5) tick();
    en2 = 1'b0;
    repeat (4) tick();
    chk("midreset_pulse_count", pulses, 1);
    chk("midreset_bus_after", sb2, 8'hF0);
    chk("midreset_drained", exp_q.size(), 0);

    // Three-stage, 16-bit instance.
    transfer(3, 16'hBEEF, 6, 5);
    chk("w16_bus_other_dut_untouched", sb2, 8'hF0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_sync.md
# data_sync

Multi-flop, enable-qualified data-bus synchronizer for clock-domain crossings. It receives a data bus and a level-type enable from a foreign clock domain and synchronizes only the enable through a flop chain. On a detected rising edge of the synchronized enable, it captures the bus into a destination-domain register. It also emits a one-cycle `enable_pulse` marking the new `sync_bus` value.

## Interface
- `NUM_STAGES`, default 2: depth of the enable synchronizer chain; legal range ≥2.
- `BUS_WIDTH`, default 8: width of the data bus.
- `clk`  input  1  destination-domain clock; all state is updated on its rising edge.
- `rst`  input  1  reset, asynchronous and active-low.
- `Unsync_bus`  input  BUS_WIDTH  data from the source domain.
- `bus_enable`  input  1  source-domain valid level.
- `sync_bus`  output  BUS_WIDTH  captured, synchronized data; registered.
- `enable_pulse`  output  1  single-cycle strobe; high in the cycle `sync_bus` takes a new value.

## Operation
- Enable synchronizer: `NUM_STAGES` flops in series. Stage 0 samples `bus_enable`; each later stage samples the previous one. `sync_en` is the last stage.
- Edge detector: one flop `sync_en_d` holds `sync_en` delayed by one cycle. `pulse_gen = sync_en & ~sync_en_d`, which is combinational.
- Data path: `sync_bus <= pulse_gen ? Unsync_bus : sync_bus`. The bus is never registered through a synchronizer chain; the mux select is the only qualifier.
- Pulse output: `enable_pulse <= pulse_gen`.
- One pulse is produced per rising edge of `bus_enable`. Holding `bus_enable` high for any number of cycles yields exactly one capture and one pulse.
- `bus_enable` low: `sync_bus` holds its last captured value and `enable_pulse` stays 0.
- Source obligation: `Unsync_bus` stays stable from `bus_enable` assertion until at least one cycle after `enable_pulse`.
- Source obligation: `bus_enable` stays low for at least `NUM_STAGES+1` clk cycles between transfers. Otherwise the second edge may be lost. This is acceptable and must not cause a spurious capture.
- Reset, asynchronous, `rst`=0: all synchronizer stages, `sync_en_d`, `sync_bus`, and `enable_pulse` go to 0 immediately.
- Reset asserted mid-transfer aborts the transfer. No pulse is produced for it.
- If `bus_enable` is already high when reset is released, it is treated as a new rising edge: capture and pulse occur after the normal latency.

## Timing
- Let edge k be the first rising clk edge at which stage 0 samples `bus_enable`=1.
- `sync_en` rises after edge k+NUM_STAGES−1.
- At edge k+NUM_STAGES: `sync_bus` = `Unsync_bus` and `enable_pulse` = 1.
- At edge k+NUM_STAGES+1: `enable_pulse` = 0.
- Capture-to-strobe alignment: `sync_bus` and `enable_pulse` change on the same edge.
- Latency for the default configuration: the pulse is high during the 3rd cycle after the sampling edge is counted as 1, i.e. 2 edges after edge k.
- Reset values: `sync_bus`=0, `enable_pulse`=0.

## Configuration
- Macro: `DATA_SYNC_PULSE_REG_EN`.
- Defined: `enable_pulse` is registered, as described above, and aligned with the `sync_bus` update.
- Undefined: `enable_pulse` = `pulse_gen` directly, combinational from flops only. It is high one cycle earlier, in the cycle before `sync_bus` updates; the consumer samples `Unsync_bus`-derived `sync_bus` on the following edge. `sync_bus` timing is unchanged.
- Reset values and single-pulse behaviour are identical in both builds.

## Test plan
- Reset: drive `rst`=0 for 1 cycle with random inputs -> `sync_bus`=0x00 and `enable_pulse`=0 asynchronously; they remain 0 after release while `bus_enable`=0.
- Basic transfer: set `Unsync_bus`=0xAA and raise `bus_enable` for 5 cycles -> `enable_pulse`=1 for exactly one cycle, 2 edges after the first sampling edge; `sync_bus`=0xAA on that edge and held afterwards.
- Hold: after the transfer, drop `bus_enable`, change `Unsync_bus` to 0x55 without re-enabling -> `sync_bus` stays 0xAA and `enable_pulse` stays 0.
- Back-to-back: transfer 0x3C, wait 4 cycles low, transfer 0xC3 -> two pulses; `sync_bus` goes 0x3C then 0xC3.
- Reset mid-transfer: raise `bus_enable` with 0xF0, assert `rst` one cycle later -> outputs 0. If `bus_enable` is still high after release, one pulse follows and `sync_bus`=0xF0 after the normal latency.
- Parameter sweep: NUM_STAGES=3 and BUS_WIDTH=16 with 0xBEEF -> pulse 3 edges after the sampling edge; `sync_bus`=0xBEEF.
